// File: rtl/spi_lcd_master.sv
// SPI master for LCD panels (mode 0): a TX FIFO of {dc, last, word} entries feeds a
// shift engine that keeps cs low across multi-word frames. Define SPI_LCD_MASTER_MISO_RD_EN for the miso read port.
//
// state | meaning
// IDLE  | cs high, waiting for the first word of a frame
// SETUP | word loaded, sclk low, MSB on mosi for DIV cycles
// SHIFT | sclk toggling every DIV cycles, DATA_W rising edges
// WAIT  | mid-frame, FIFO empty: cs low, sclk low, mosi held
// HOLD  | last word sent, cs low for DIV more cycles
// GAP   | cs high for CS_GAP cycles before the next frame
module spi_lcd_master #(
    parameter int DATA_W     = 8,
    parameter int DIV        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_dc,
    input  logic              i_last,
    output logic              sclk,
    output logic              mosi,
    output logic              dc,
    output logic              cs,
    input  logic              miso,
    output logic              o_busy,
    output logic              o_done
`ifdef SPI_LCD_MASTER_MISO_RD_EN
    ,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid
`endif
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int CNT_W = $clog2((DIV > CS_GAP ? DIV : CS_GAP) + 1);
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_WAIT, S_HOLD, S_GAP} state_t;

    state_t             state, state_nxt;
    logic [DATA_W+1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic [DATA_W+1:0]  head;
    logic               push, load, empty;
    logic [DATA_W-1:0]  shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sclk_r, dc_r, last_r, done_r;
    logic               cnt_zero, end_word, rise;

    assign o_ready  = (count != (AW+1)'(FIFO_DEPTH));
    assign push     = i_valid && o_ready;
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign cnt_zero = (cnt == '0);
    assign rise     = (state == S_SHIFT) && cnt_zero && !sclk_r;
    assign end_word = (state == S_SHIFT) && cnt_zero && sclk_r && (bit_cnt == '0);
    assign load     = !empty && ((state == S_IDLE) || (state == S_WAIT) || (end_word && !last_r));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {i_dc, i_last, i_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty) state_nxt = S_SETUP;
            S_SETUP: if (cnt_zero) state_nxt = S_SHIFT;
            S_SHIFT: if (end_word) state_nxt = last_r ? S_HOLD : (!empty ? S_SETUP : S_WAIT);
            S_WAIT:  if (!empty) state_nxt = S_SETUP;
            S_HOLD:  if (cnt_zero) state_nxt = S_GAP;
            S_GAP:   if (cnt_zero) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cs     = (state == S_IDLE) || (state == S_GAP);
        o_busy = (state != S_IDLE);
        sclk   = sclk_r;
        mosi   = shift_reg[DATA_W-1];
        dc     = dc_r;
        o_done = done_r;
    end

    // A load always restarts the half-period timer, so SETUP lasts DIV cycles and
    // SHIFT then waits one more half period before the first rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            dc_r      <= 1'b0;
            last_r    <= 1'b0;
            sclk_r    <= 1'b0;
            cnt       <= '0;
            bit_cnt   <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (load) begin
                shift_reg <= head[DATA_W-1:0];
                last_r    <= head[DATA_W];
                dc_r      <= head[DATA_W+1];
                sclk_r    <= 1'b0;
                cnt       <= DIV_M1;
                bit_cnt   <= BIT_W'(DATA_W - 1);
            end else begin
                case (state)
                    S_SETUP: cnt <= cnt_zero ? DIV_M1 : cnt - 1'b1;
                    S_SHIFT: begin
                        if (!cnt_zero) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            cnt    <= DIV_M1;
                            sclk_r <= !sclk_r;
                            if (sclk_r && bit_cnt != '0) begin
                                shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                                bit_cnt   <= bit_cnt - 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (cnt_zero) begin
                            done_r <= 1'b1;
                            cnt    <= GAP_M1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_GAP:   if (!cnt_zero) cnt <= cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_LCD_MASTER_MISO_RD_EN
    logic [DATA_W-1:0] rx_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_shift <= '0;
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
        end else begin
            if (rise)     rx_shift <= {rx_shift[DATA_W-2:0], miso};
            if (end_word) o_rdata  <= rx_shift;
            o_rvalid <= end_word;
        end
    end
`else
    logic unused_rx;
    assign unused_rx = miso ^ rise;
`endif

endmodule
